// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates BEQ/BNE/BLEZ/BGTZ and registers the next PC and mispredict flag.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [5:0]       OP,
    input  logic [WIDTH-1:0] RN1,
    input  logic [WIDTH-1:0] RN2,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [15:0]      imm16,
    input  logic             pred_taken,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic             is_branch,
    output logic             taken,
    output logic [WIDTH-1:0] target,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef enum logic {
        EMPTY,
        VALID
    } state_t;

    state_t           state;
    state_t           next_state;

    logic             cur_is_branch;
    logic             cur_taken;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] branch_addr;

    logic             is_branch_r;
    logic             taken_r;
    logic             pred_r;
    logic [WIDTH-1:0] target_r;

    // Sign-extension via a sized cast stays legal even when WIDTH is exactly 16.
    assign imm_ext     = WIDTH'($signed(imm16));
    assign branch_addr = pc_plus4 + (imm_ext << 2);

    always_comb begin
        cur_is_branch = 1'b0;
        cur_taken     = 1'b0;
        case (OP)
            6'd4: begin
                cur_is_branch = 1'b1;
                cur_taken     = (RN1 == RN2);
            end
            6'd5: begin
                cur_is_branch = 1'b1;
                cur_taken     = (RN1 != RN2);
            end
            6'd6: begin
                cur_is_branch = 1'b1;
                cur_taken     = RN1[WIDTH-1] | (RN1 == '0);
            end
            6'd7: begin
                cur_is_branch = 1'b1;
                cur_taken     = ~RN1[WIDTH-1] & (RN1 != '0);
            end
            default: begin
                cur_is_branch = 1'b0;
                cur_taken     = 1'b0;
            end
        endcase
    end

    // Flush wins over stall so a squashed slot never survives a held pipeline.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else if (!stall) begin
            next_state = in_valid ? VALID : EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_branch_r <= 1'b0;
            taken_r     <= 1'b0;
            pred_r      <= 1'b0;
            target_r    <= '0;
        end else if (!stall) begin
            is_branch_r <= cur_is_branch;
            taken_r     <= cur_taken;
            pred_r      <= pred_taken;
            target_r    <= cur_taken ? branch_addr : pc_plus4;
        end
    end

    assign out_valid  = (state == VALID);
    assign is_branch  = out_valid & is_branch_r;
    assign taken      = out_valid & taken_r;
    assign target     = target_r;
    assign mispredict = out_valid & is_branch_r & (taken_r != pred_r);

`ifdef BRANCH_STATS_EN
    logic             count_branch;
    logic             count_mispred;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    assign count_branch  = ~stall & ~flush & in_valid & cur_is_branch;
    assign count_mispred = count_branch & (cur_taken != pred_taken);

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else begin
            if (count_branch && (branch_cnt_r != '1)) begin
                branch_cnt_r <= branch_cnt_r + 1'b1;
            end
            if (count_mispred && (mispred_cnt_r != '1)) begin
                mispred_cnt_r <= mispred_cnt_r + 1'b1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_r;
    assign mispred_cnt = mispred_cnt_r;
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized self-checking bench for branch_resolve_unit against a behavioural model.
// Counter expectations follow whether BRANCH_STATS_EN is defined for the build.
module tb_branch_resolve_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [5:0]       op;
    logic [WIDTH-1:0] rn1;
    logic [WIDTH-1:0] rn2;
    logic [WIDTH-1:0] pc_plus4;
    logic [15:0]      imm16;
    logic             pred_taken;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic             is_branch;
    logic             taken;
    logic [WIDTH-1:0] target;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the registered result.
    bit             m_valid;
    bit             m_branch;
    bit             m_taken;
    bit             m_pred;
    logic [WIDTH-1:0] m_target;
    int             m_bcnt;
    int             m_mcnt;

    branch_resolve_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .OP         (op),
        .RN1        (rn1),
        .RN2        (rn2),
        .pc_plus4   (pc_plus4),
        .imm16      (imm16),
        .pred_taken (pred_taken),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .is_branch  (is_branch),
        .taken      (taken),
        .target     (target),
        .mispredict (mispredict),
        .branch_cnt (branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit condTrue(input logic [5:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint sa;
        sa = longint'($signed(a));
        case (o)
            6'd4:    return a == b;
            6'd5:    return a != b;
            6'd6:    return sa <= 0;
            6'd7:    return sa > 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        m_valid  = 1'b0;
        m_branch = 1'b0;
        m_taken  = 1'b0;
        m_pred   = 1'b0;
        m_target = '0;
        m_bcnt   = 0;
        m_mcnt   = 0;
    endtask

    task automatic modelEdge();
        longint addr;
        bit     br;
        bit     tk;
        br = (op >= 6'd4) && (op <= 6'd7);
        tk = condTrue(op, rn1, rn2);
        if (!stall) begin
            addr     = longint'(pc_plus4) + 4 * longint'($signed(imm16));
            m_valid  = in_valid && !flush;
            m_branch = br;
            m_taken  = tk;
            m_pred   = pred_taken;
            m_target = tk ? addr[WIDTH-1:0] : pc_plus4;
            if (STATS && in_valid && !flush && br) begin
                if (m_bcnt < CNT_MAX) m_bcnt++;
                if (tk != pred_taken && m_mcnt < CNT_MAX) m_mcnt++;
            end
        end else if (flush) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        checkOutput({tag, ".is_branch"}, 64'(is_branch), 64'(m_valid && m_branch));
        checkOutput({tag, ".taken"}, 64'(taken), 64'(m_valid && m_taken));
        checkOutput({tag, ".mispredict"}, 64'(mispredict), 64'(m_valid && m_branch && (m_taken != m_pred)));
        if (m_valid) checkOutput({tag, ".target"}, 64'(target), 64'(m_target));
        checkOutput({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(m_bcnt));
        checkOutput({tag, ".mispred_cnt"}, 64'(mispred_cnt), 64'(m_mcnt));
    endtask

    task automatic applyStimulus(input string tag, input bit v, input logic [5:0] o,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] pc, input logic [15:0] imm,
                                 input bit pr, input bit st, input bit fl);
        in_valid   = v;
        op         = o;
        rn1        = a;
        rn2        = b;
        pc_plus4   = pc;
        imm16      = imm;
        pred_taken = pr;
        stall      = st;
        flush      = fl;
        @(posedge clk);
        #1;
        modelEdge();
        compareAll(tag);
    endtask

    // Asserts reset between edges and checks the immediate asynchronous clear.
    task automatic pulseReset(input string tag);
        rst = 1'b1;
        #2;
        modelReset();
        compareAll(tag);
        checkOutput({tag, ".target_zero"}, 64'(target), 64'h0);
        @(posedge clk);
        #1;
        compareAll(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [5:0]       o;
        int               r;

        rst = 1'b1; in_valid = 1'b0; op = '0; rn1 = '0; rn2 = '0;
        pc_plus4 = '0; imm16 = '0; pred_taken = 1'b0; stall = 1'b0; flush = 1'b0;
        modelReset();
        #1;
        pulseReset("reset");

        applyStimulus("bne_taken", 1, 6'd5, 32'd2, 32'd3, 32'h100, 16'd4, 0, 0, 0);
        checkOutput("bne_target_const", 64'(target), 64'h110);
        checkOutput("bne_mispred_const", 64'(mispredict), 64'h1);

        applyStimulus("beq_back", 1, 6'd4, 32'd1, 32'd1, 32'h100, 16'hFFFF, 1, 0, 0);
        checkOutput("beq_back_const", 64'(target), 64'hFC);
        applyStimulus("beq_not", 1, 6'd4, 32'd1, 32'd2, 32'h200, 16'hFFFF, 0, 0, 0);
        applyStimulus("blez_neg", 1, 6'd6, 32'h80000000, 32'd5, 32'h300, 16'd8, 1, 0, 0);
        applyStimulus("bgtz_neg", 1, 6'd7, 32'h80000000, 32'd5, 32'h300, 16'd8, 1, 0, 0);
        applyStimulus("bgtz_one", 1, 6'd7, 32'd1, 32'd0, 32'h300, 16'd8, 0, 0, 0);
        applyStimulus("blez_zero", 1, 6'd6, 32'd0, 32'd9, 32'hFFFFFFFC, 16'd1, 1, 0, 0);
        applyStimulus("nonbranch", 1, 6'd8, 32'd1, 32'd1, 32'h400, 16'd3, 1, 0, 0);

        applyStimulus("pre_stall", 1, 6'd5, 32'd7, 32'd8, 32'h500, 16'd2, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall_hold", 1, 6'd4, $urandom, $urandom, $urandom, 16'($urandom), 0, 1, 0);
        applyStimulus("flush_stall", 1, 6'd4, 32'd1, 32'd1, 32'h600, 16'd1, 0, 1, 1);
        applyStimulus("after_flush", 1, 6'd4, 32'd3, 32'd3, 32'h700, 16'd1, 0, 0, 0);
        applyStimulus("flush_nostall", 1, 6'd5, 32'd3, 32'd4, 32'h800, 16'd1, 0, 0, 1);
        stall = 1'b1;
        flush = 1'b1;
        pulseReset("reset_mid");
        applyStimulus("post_reset", 1, 6'd5, 32'd2, 32'd3, 32'h100, 16'd4, 0, 0, 0);

        pulseReset("reset_cnt");
        for (int i = 0; i < 5; i++)
            applyStimulus("cnt_sat", 1, 6'd4, 32'd1, 32'd1, 32'h40, 16'd1, 0, 0, 0);
        checkOutput("cnt_sat_branch", 64'(branch_cnt), STATS ? 64'd3 : 64'd0);
        checkOutput("cnt_sat_mispred", 64'(mispred_cnt), STATS ? 64'd3 : 64'd0);

        pulseReset("reset_rand");
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            o = (r < 8) ? 6'(4 + (r % 4)) : 6'($urandom_range(0, 63));
            case ($urandom_range(0, 4))
                0:       a = '0;
                1:       a = 32'h80000000;
                2:       a = 32'd1;
                3:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            if ($urandom_range(0, 99) == 0) begin
                pulseReset("rand_reset");
            end else begin
                applyStimulus("rand", $urandom_range(0, 99) < 85, o, a, b, $urandom,
                              16'($urandom), 1'($urandom), $urandom_range(0, 99) < 15,
                              $urandom_range(0, 99) < 10);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
